// File: rtl/clk_div_bank.sv
// Multi-channel programmable divided-clock / tick generator with glitch-free half-period updates.
// Optional macro CLK_DIV_SYNC_EN adds a sync input that realigns all running channels.
module clk_div_bank #(
  parameter int NCH        = 4,
  parameter int CW         = 16,
  parameter int SW         = 2,
  parameter int DEFAULT_HP = 50000
) (
  input  logic           clk,
  input  logic           reset,
`ifdef CLK_DIV_SYNC_EN
  input  logic           sync,
`endif
  input  logic [NCH-1:0] en,
  input  logic           div_wr,
  input  logic [SW-1:0]  div_sel,
  input  logic [CW-1:0]  div_data,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] div_pend
);

  localparam logic [CW-1:0] HP_RST = CW'(DEFAULT_HP);
  localparam logic [SW:0]   NCH_L  = (SW+1)'(NCH);

  logic wr_ok;
  logic sync_w;

  assign wr_ok = div_wr && ({1'b0, div_sel} < NCH_L);

`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hp_q, hp_d;
    logic [CW-1:0] pend_val_q, pend_val_d;
    logic [CW-1:0] hp_m1;
    logic          pend_q, pend_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic          wr_hit, wrap, sync_hit;

    // A half-period of 0 behaves as 1, so the wrap point never underflows.
    assign hp_m1    = (hp_q == '0) ? '0 : hp_q - CW'(1);
    assign wr_hit   = wr_ok && (div_sel == SW'(i));
    assign wrap     = en[i] && (cnt_q == hp_m1);
    assign sync_hit = en[i] && sync_w;

    always_comb begin
      // NOTE: every next-state signal gets a default first so no branch can infer a latch.
      cnt_d      = cnt_q;
      hp_d       = hp_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      clk_d      = clk_q;
      tick_d     = 1'b0;

      if (!en[i]) begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (wr_hit) begin
          hp_d   = div_data;
          pend_d = 1'b0;
        end
      end else if (sync_hit || wrap) begin
        // Sync outranks a wrap: it forces low without a tick; either one is a safe apply point.
        cnt_d = '0;
        if (sync_hit) begin
          clk_d = 1'b0;
        end else begin
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
        end
        if (wr_hit) begin
          hp_d   = div_data;
          pend_d = 1'b0;
        end else if (pend_q) begin
          hp_d   = pend_val_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (wr_hit) begin
          pend_val_d = div_data;
          pend_d     = 1'b1;
        end
      end
    end

    // NOTE: hp is a handful of per-channel flops, not a memory, so it is reset to a known default.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q      <= '0;
        hp_q       <= HP_RST;
        pend_val_q <= '0;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        cnt_q      <= cnt_d;
        hp_q       <= hp_d;
        pend_val_q <= pend_val_d;
        pend_q     <= pend_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_out[i]  = clk_q;
    assign tick[i]     = tick_q;
    assign div_pend[i] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Table-driven self-checking bench for clk_div_bank (NCH=4, CW=16, SW=3, DEFAULT_HP=4).
// Each vector's expected outputs go through a scoreboard queue and are compared after the edge.
module tb_clk_div_bank;

  logic        clk;
  logic        reset;
  logic        sync;
  logic [3:0]  en;
  logic        div_wr;
  logic [2:0]  div_sel;
  logic [15:0] div_data;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [3:0]  div_pend;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  en;
    logic        wr;
    logic [2:0]  sel;
    logic [15:0] data;
    logic        sync;
    logic [3:0]  e_clk;
    logic [3:0]  e_tick;
    logic [3:0]  e_pend;
  } vec_t;

  typedef struct {
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    logic [3:0] e_pend;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  clk_div_bank #(
    .NCH(4), .CW(16), .SW(3), .DEFAULT_HP(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef CLK_DIV_SYNC_EN
    .sync     (sync),
`endif
    .en       (en),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_data (div_data),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_pend (div_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  function automatic void add(input logic [3:0] en_v, input logic wr_v, input logic [2:0] sel_v,
                              input logic [15:0] d_v, input logic s_v,
                              input logic [3:0] c, input logic [3:0] t, input logic [3:0] p);
    vecs.push_back(vec_t'{en_v, wr_v, sel_v, d_v, s_v, c, t, p});
  endfunction

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    en       = v.en;
    div_wr   = v.wr;
    div_sel  = v.sel;
    div_data = v.data;
    sync     = v.sync;
    sb.push_back(exp_t'{v.e_clk, v.e_tick, v.e_pend, id});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d clk_out", e.id),  clk_out,  e.e_clk);
    check($sformatf("vec%0d tick", e.id),     tick,     e.e_tick);
    check($sformatf("vec%0d div_pend", e.id), div_pend, e.e_pend);
  endtask

  task automatic run_table(input int base);
    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], base + k);
    vecs.delete();
    div_wr = 1'b0;
    sync   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = '0; div_wr = 1'b0; div_sel = '0; div_data = '0; sync = 1'b0;
    #12;
    check("reset clk_out",  clk_out,  4'b0000);
    check("reset tick",     tick,     4'b0000);
    check("reset div_pend", div_pend, 4'b0000);
    #10 reset = 1'b0;

    // ch0 free-running at default hp=4: rise on 4th edge, period 8.
    for (int k = 1; k <= 12; k++) begin
      logic hi, tk;
      hi = ((k / 4) % 2) == 1;
      tk = (k % 8) == 4;
      add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, {3'b000, hi}, {3'b000, tk}, 4'b0000);
    end
    // Write hp=2 at cnt=1: pending until the wrap, old half-period completes.
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000); // 13
    add(4'b0001, 1'b1, 3'd0, 16'd2, 1'b0, 4'b0001, 4'b0000, 4'b0001); // 14
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0001); // 15
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 16
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 17
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0000); // 18
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000); // 19
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 20
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 21
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0000); // 22
    // hp=0 written to disabled ch1, then enabled: toggles every clock.
    add(4'b0001, 1'b1, 3'd1, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000); // 23
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000); // 24
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 25
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0011, 4'b0011, 4'b0000); // 26
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000); // 27
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000); // 28
    // Disable all, restore ch0 hp=4 directly, then drop en[0] at cnt=2 while high.
    add(4'b0000, 1'b1, 3'd0, 16'd4, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 29
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 30
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 31
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 32
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0000); // 33
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000); // 34
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000); // 35
    add(4'b0000, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 36
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 37
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 38
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 39
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0000); // 40
    // Out-of-range select must not alias onto ch1 (ch1 keeps hp=0).
    add(4'b0001, 1'b1, 3'd5, 16'd3, 1'b0, 4'b0001, 4'b0000, 4'b0000); // 41
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0011, 4'b0010, 4'b0000); // 42
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0000); // 43
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000); // 44
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // 45
    add(4'b0011, 1'b1, 3'd0, 16'd2, 1'b0, 4'b0010, 4'b0010, 4'b0001); // 46
    run_table(0);

    // Asynchronous reset mid-period with a pending value outstanding.
    #2 reset = 1'b1;
    #1;
    check("async reset clk_out",  clk_out,  4'b0000);
    check("async reset tick",     tick,     4'b0000);
    check("async reset div_pend", div_pend, 4'b0000);
    @(posedge clk);
    #3 reset = 1'b0;

    // Both channels back at hp=4; the discarded pending hp=2 must not appear.
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] c, t;
      c = (k >= 4 && k < 8) ? 4'b0011 : 4'b0000;
      t = (k == 4) ? 4'b0011 : 4'b0000;
      add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, c, t, 4'b0000);
    end
    run_table(100);

`ifdef CLK_DIV_SYNC_EN
    // ch0 hp=4, ch1 hp=3; sync lands where ch1 would rise, suppressing that tick.
    add(4'b0000, 1'b1, 3'd1, 16'd3, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S1
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S2
    add(4'b0001, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S3
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S4
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0000); // S5
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0011, 4'b0010, 4'b0000); // S6
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0011, 4'b0000, 4'b0000); // S7
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0011, 4'b0000, 4'b0000); // S8
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S9
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S10
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S11
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000); // S12 sync
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S13
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // S14
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000); // S15
    add(4'b0011, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0011, 4'b0001, 4'b0000); // S16
    run_table(200);
`endif

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
